// File: rtl/rca_wide_seq.sv
// rca_wide_seq: multi-word add/subtract sequencer driving a registered 32-bit ripple-carry adder wrapper.
module rca_wide_seq #(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SUB,
    input  logic                  CIN,
    input  logic [32*WORDS-1:0]   OP_A,
    input  logic [32*WORDS-1:0]   OP_B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [32*WORDS-1:0]   RESULT,
    output logic                  COUT,
    output logic                  OVF,
    output logic                  ZERO,
    output logic [31:0]           ADD_A,
    output logic [31:0]           ADD_B,
    output logic                  ADD_C_IN,
    output logic                  ADD_FLAG,
    input  logic [31:0]           ADD_S,
    input  logic                  ADD_C_OUT
);
    localparam int W  = 32*WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam int CW = ADD_LAT > 0 ? $clog2(ADD_LAT+1) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic            sub_q, sub_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;
    logic [IW-1:0]   idx_q, idx_d, nidx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     add_a_q, add_a_d, add_b_q, add_b_d;
    logic            add_cin_q, add_cin_d, add_flag_q, add_flag_d;

    assign nidx = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_cin_d  = add_cin_q;
        add_flag_d = add_flag_q;
        if (state_q == IDLE) begin
            if (START) begin
                a_d        = OP_A;
                b_d        = OP_B;
                sub_d      = SUB;
                add_a_d    = OP_A[31:0];
                add_b_d    = OP_B[31:0];
                add_flag_d = SUB;
                add_cin_d  = SUB | CIN;
                idx_d      = '0;
                cnt_d      = '0;
                state_d    = RUN;
            end
        end else if (cnt_q != CW'(ADD_LAT)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            result_d[32*idx_q +: 32] = ADD_S;
            cnt_d = '0;
            if (idx_q != IW'(WORDS-1)) begin
                add_a_d   = a_q[32*nidx +: 32];
                add_b_d   = b_q[32*nidx +: 32];
                add_cin_d = ADD_C_OUT;
                idx_d     = nidx;
            end else begin
                // overflow uses the effective (post-inversion) sign of B
                cout_d     = ADD_C_OUT;
                ovf_d      = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (ADD_S[31] != a_q[W-1]);
                zero_d     = result_d == '0;
                done_d     = 1'b1;
                add_a_d    = '0;
                add_b_d    = '0;
                add_cin_d  = 1'b0;
                add_flag_d = 1'b0;
                idx_d      = '0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            add_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            add_flag_q <= add_flag_d;
        end
    end

    assign BUSY     = state_q == RUN;
    assign DONE     = done_q;
    assign RESULT   = result_q;
    assign COUT     = cout_q;
    assign OVF      = ovf_q;
    assign ZERO     = zero_q;
    assign ADD_A    = add_a_q;
    assign ADD_B    = add_b_q;
    assign ADD_C_IN = add_cin_q;
    assign ADD_FLAG = add_flag_q;
endmodule

// File: tb/tb_rca_wide_seq.sv
// tb_rca_wide_seq: directed vectors for rca_wide_seq with a two-stage registered adder wrapper model.
module tb_rca_wide_seq;
    logic         CLK = 0, RST = 1, START = 0, SUB = 0, CIN = 0;
    logic [127:0] OP_A = '0, OP_B = '0, RESULT;
    logic         BUSY, DONE, COUT, OVF, ZERO, ADD_C_IN, ADD_FLAG, ADD_C_OUT;
    logic [31:0]  ADD_A, ADD_B, ADD_S;
    logic [31:0]  s1_a, s1_b;
    logic         s1_c, s1_f;
    int total = 0, bad = 0;

    rca_wide_seq #(.WORDS(4), .ADD_LAT(2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .CIN(CIN),
        .OP_A(OP_A), .OP_B(OP_B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .COUT(COUT), .OVF(OVF), .ZERO(ZERO), .ADD_A(ADD_A), .ADD_B(ADD_B),
        .ADD_C_IN(ADD_C_IN), .ADD_FLAG(ADD_FLAG), .ADD_S(ADD_S), .ADD_C_OUT(ADD_C_OUT)
    );

    always #5 CLK = ~CLK;

    // operand register stage followed by result register stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            {s1_a, s1_b, s1_c, s1_f} <= '0;
            {ADD_C_OUT, ADD_S}       <= '0;
        end else begin
            {s1_a, s1_b, s1_c, s1_f} <= {ADD_A, ADD_B, ADD_C_IN, ADD_FLAG};
            {ADD_C_OUT, ADD_S}       <= {1'b0, s1_a} + {1'b0, (s1_f ? ~s1_b : s1_b)} + {32'd0, s1_c};
        end
    end

    typedef struct {
        logic         sub;
        logic         cin;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat;
        @(negedge CLK);
        SUB = v.sub; CIN = v.cin; OP_A = v.a; OP_B = v.b; START = 1;
        @(negedge CLK);
        START = 0;
        chk($sformatf("v%0d_busy", i), BUSY, 1);
        chk($sformatf("v%0d_flag", i), ADD_FLAG, v.sub);
        chk($sformatf("v%0d_cin0", i), ADD_C_IN, v.sub | v.cin);
        chk($sformatf("v%0d_adda0", i), ADD_A, v.a[31:0]);
        chk($sformatf("v%0d_addb0", i), ADD_B, v.b[31:0]);
        wait_done(lat);
        chk($sformatf("v%0d_lat", i), lat, 12);
        chk($sformatf("v%0d_busy_done", i), BUSY, 0);
        chk($sformatf("v%0d_res", i), RESULT, v.res);
        chk($sformatf("v%0d_cout", i), COUT, v.cout);
        chk($sformatf("v%0d_ovf", i), OVF, v.ovf);
        chk($sformatf("v%0d_zero", i), ZERO, v.zero);
        @(negedge CLK);
        chk($sformatf("v%0d_pulse", i), DONE, 0);
        chk($sformatf("v%0d_idle_add", i), {ADD_A, ADD_B, ADD_C_IN, ADD_FLAG}, 0);
        chk($sformatf("v%0d_hold", i), RESULT, v.res);
    endtask

    vec_t vecs[7];
    int   lat, dones;
    logic [127:0] ones, msb;

    initial begin
        ones = '1;
        msb  = 128'd1 << 127;
        vecs[0] = '{1'b0, 1'b0, 128'hFFFF_FFFF, 128'd1, 128'h1_0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, ones, 128'd1, 128'd0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 128'd5, 128'd7, ones - 128'd1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, ones >> 1, 128'd1, msb, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 128'd0, 128'd0, 128'd1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978,
                    128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 128'd0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, msb, 128'd1, ones >> 1, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge CLK);
        chk("rst_out", {BUSY, DONE, COUT, OVF, ZERO, ADD_C_IN, ADD_FLAG}, 0);
        chk("rst_res", RESULT, 0);
        chk("rst_add", {ADD_A, ADD_B}, 0);
        RST = 0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // START mid-operation is ignored
        @(negedge CLK);
        SUB = 0; CIN = 0; OP_A = 128'd1; OP_B = 128'd2; START = 1;
        @(negedge CLK);
        START = 0;
        repeat (2) @(negedge CLK);
        SUB = 1; OP_A = 128'd100; OP_B = 128'd100; START = 1;
        @(negedge CLK);
        START = 0;
        wait_done(lat);
        chk("busy_start_lat", lat, 9);
        chk("busy_start_res", RESULT, 128'd3);
        @(negedge CLK);

        // START held through DONE gives back-to-back operation
        SUB = 0; OP_A = 128'd10; OP_B = 128'd20; START = 1;
        @(negedge CLK);
        OP_A = 128'd40; OP_B = 128'd2;
        wait_done(lat);
        chk("b2b_lat1", lat, 12);
        chk("b2b_res1", RESULT, 128'd30);
        @(negedge CLK);
        START = 0;
        chk("b2b_busy", BUSY, 1);
        chk("b2b_adda", ADD_A, 32'd40);
        wait_done(lat);
        chk("b2b_lat2", lat, 12);
        chk("b2b_res2", RESULT, 128'd42);
        @(negedge CLK);

        // asynchronous reset mid-operation
        OP_A = ones; OP_B = 128'd7; START = 1;
        @(negedge CLK);
        START = 0;
        repeat (4) @(negedge CLK);
        #1 RST = 1;
        #1;
        chk("arst_out", {BUSY, DONE, COUT, OVF, ZERO, ADD_C_IN, ADD_FLAG}, 0);
        chk("arst_res", RESULT, 0);
        chk("arst_add", {ADD_A, ADD_B}, 0);
        @(negedge CLK);
        RST = 0;
        dones = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
        end
        chk("arst_no_done", dones, 0);
        run_vec(7, '{1'b0, 1'b0, 128'd2, 128'd3, 128'd5, 1'b0, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rca_wide_seq.md
Name: rca_wide_seq

Overview:
- Multi-word add/subtract sequencer that time-shares the registered 32-bit ripple-carry adder wrapper (operand register stage, RCA_32, result register stage) to compute WORDS×32-bit sums.
- Feeds one 32-bit word per pass, least-significant word first, and chains each pass's carry-out into the next pass's carry-in.
- Sits beside the adder wrapper; its ADD_* ports connect directly to that wrapper's A/B/C_in/FLAG/S_out/C_out.

Parameters:
WORDS, 4, number of 32-bit words per operand (≥1); operand width = 32*WORDS
ADD_LAT, 2, clock edges from the adder wrapper sampling its inputs to its outputs being valid

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  request; accepted only in IDLE
SUB  input  1  0 = add, 1 = subtract (A − B); sampled with START
CIN  input  1  carry-in for word 0 when SUB=0; ignored when SUB=1
OP_A  input  32*WORDS  operand A; sampled with START
OP_B  input  32*WORDS  operand B; sampled with START
BUSY  output  1  operation in progress
DONE  output  1  one-cycle pulse, result valid
RESULT  output  32*WORDS  wide sum/difference
COUT  output  1  final carry-out; for SUB, 1 = no borrow
OVF  output  1  signed overflow of the wide operation
ZERO  output  1  RESULT == 0
ADD_A  output  32  word to adder A
ADD_B  output  32  word to adder B (uninverted; the adder inverts when FLAG=1)
ADD_C_IN  output  1  adder carry-in
ADD_FLAG  output  1  adder add/sub select (= latched SUB)
ADD_S  input  32  adder sum (registered in the wrapper)
ADD_C_OUT  input  1  adder carry-out (registered in the wrapper)

Behaviour:
- Reset: all outputs 0, FSM to IDLE, word index and latency counter 0. Reset mid-operation aborts it; no DONE is issued.
- States:
  - IDLE: BUSY=0. START=1 at an edge latches OP_A, OP_B and SUB. ADD_A/ADD_B are loaded with word 0 and ADD_FLAG with SUB. ADD_C_IN is loaded with SUB ? 1 : CIN. idx=0, cnt=0, go to RUN.
  - RUN: BUSY=1. All ADD_* outputs are registered and held stable for the whole pass. cnt increments each edge.
  - Capture edge (cnt == ADD_LAT): RESULT[32*idx +: 32] <= ADD_S. If idx < WORDS−1: ADD_A/ADD_B <= word idx+1, ADD_C_IN <= ADD_C_OUT, idx++, cnt=0.
  - Last word (idx == WORDS−1): COUT <= ADD_C_OUT; compute OVF and ZERO; DONE <= 1 next cycle; go to IDLE (BUSY=0 in the same cycle as DONE).
- Timing:
  - Each pass takes ADD_LAT+1 edges.
  - DONE is asserted WORDS*(ADD_LAT+1) cycles after the START acceptance edge: 12 for the defaults.
  - DONE is high exactly one cycle.
- Arithmetic: the adder computes A + (FLAG ? ~B : B) + C_in; the controller does no inversion itself.
- OVF = (a_msb == b_eff_msb) && (sum_msb != a_msb), where a_msb = OP_A[MSB], b_eff_msb = OP_B[MSB] ^ SUB, sum_msb = RESULT[MSB].
- ZERO is evaluated on the complete RESULT, including the final word.
- RESULT, COUT, OVF and ZERO hold until the next accepted START. On START acceptance only the internal state changes; the outputs are overwritten progressively.
- START while BUSY=1 is ignored; this includes the final capture cycle. START present in the DONE cycle is accepted, giving back-to-back operation.
- OP_A, OP_B and SUB changing during RUN have no effect.
- After the final capture, ADD_* outputs return to 0 in IDLE.
- WORDS=1 degenerates to a single pass with the same timing rules.

Test Plan:
- Carry ripple: WORDS=4, OP_A=0x0…0_FFFFFFFF, OP_B=1, SUB=0, CIN=0 → RESULT=0x0…1_00000000, COUT=0, OVF=0, ZERO=0, DONE exactly 12 cycles after the START edge, BUSY high 12 cycles.
- Full wrap: OP_A = all-ones (128 bits), OP_B=1, add → RESULT=0, COUT=1, ZERO=1, OVF=0.
- Subtract with borrow: OP_A=5, OP_B=7, SUB=1, CIN=1 (ignored) → RESULT=0xFFFF…FFFE, COUT=0, OVF=0; check ADD_FLAG=1 and ADD_C_IN=1 for word 0.
- Signed overflow: OP_A=0x7FFF…FFFF, OP_B=1, add → RESULT=0x8000…0000, OVF=1, COUT=0.
- Handshake: pulse START at cycle 3 of a busy operation → ignored, operands unchanged. Hold START through the DONE cycle → second operation accepted on that edge, second DONE 12 cycles later.
- Reset: assert RST asynchronously at cycle 5 of an operation → all outputs 0 immediately, no DONE. Release RST and START OP_A=2, OP_B=3 → RESULT=5 after 12 cycles.
